mxint_block_encoder: RTL and testbench

- Converts a serial stream of signed fixed-point values into MXINT blocks: BLOCK_SIZE signed mantissas plus one shared signed exponent.
- Sits at the output of fixed-point datapaths, for example after dequantised accumulation. It produces the mantissa/exponent block format that MXINT dot-product and linear stages consume.
- Collects one value per handshake, scans the block for the largest magnitude, then shifts every element to the shared scale.

---
 rtl/mxint_pkg.sv | 16 +
 rtl/mxint_leading_bit.sv | 21 ++
 rtl/mxint_block_encoder.sv | 156 +++++++++++++++
 tb/tb_mxint_block_encoder.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mxint_pkg.sv
// rtl/mxint_pkg.sv - shared FSM state type and width helper for the MXINT block encoder
package mxint_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SCAN    = 2'd1,
    SHIFT   = 2'd2,
    OUT     = 2'd3
  } state_e;

  // Signed width able to hold B - (M-1) for any B in 0..W-1
  function automatic int shift_width(input int in_width);
    return $clog2(in_width) + 2;
  endfunction

endpackage

// File: rtl/mxint_leading_bit.sv
// rtl/mxint_leading_bit.sv - significant bit count of a signed value
// b = 1 + index of the highest bit differing from the sign bit; 0 for values 0 and -1.
module mxint_leading_bit #(
  parameter int W = 16
) (
  input  logic [W-1:0]         x,
  output logic [$clog2(W)-1:0] b
);

  logic [W-2:0] diff;

  assign diff = x[W-2:0] ^ {(W - 1){x[W-1]}};

  always_comb begin
    b = '0;
    for (int k = 0; k < W - 1; k++) begin
      if (diff[k]) b = ($clog2(W))'(k + 1);
    end
  end

endmodule

// File: rtl/mxint_block_encoder.sv
// rtl/mxint_block_encoder.sv - serial fixed-point to MXINT block encoder (collect, scan, shift, out)
// Optional MXINT_BLOCK_ENCODER_ROUND_EN: round half up with positive saturation instead of truncation.
module mxint_block_encoder
  import mxint_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0  = 16,
  parameter int DATA_IN_0_PRECISION_1  = 8,
  parameter int DATA_OUT_0_PRECISION_0 = 8,
  parameter int DATA_OUT_0_PRECISION_1 = 8,
  parameter int BLOCK_SIZE             = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0,
  input  logic                              data_in_0_valid,
  output logic                              data_in_0_ready,
  output logic [DATA_OUT_0_PRECISION_0-1:0] mdata_out_0 [BLOCK_SIZE-1:0],
  output logic [DATA_OUT_0_PRECISION_1-1:0] edata_out_0,
  output logic                              data_out_0_valid,
  input  logic                              data_out_0_ready
);

  localparam int W     = DATA_IN_0_PRECISION_0;
  localparam int FRAC  = DATA_IN_0_PRECISION_1;
  localparam int M     = DATA_OUT_0_PRECISION_0;
  localparam int E     = DATA_OUT_0_PRECISION_1;
  localparam int N     = BLOCK_SIZE;
  localparam int BW    = $clog2(W);
  localparam int CW    = (N > 1) ? $clog2(N) : 1;
  localparam int SW    = shift_width(W);
  localparam int E_MIN = -(2 ** (E - 1));
  localparam int E_MAX = (2 ** (E - 1)) - 1;
`ifdef MXINT_BLOCK_ENCODER_ROUND_EN
  localparam logic signed [W:0] MANT_MAX = (W + 1)'((2 ** (M - 1)) - 1);
`endif

  state_e                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [W-1:0]          elem_q [N-1:0];
  logic [W-1:0]          elem_d [N-1:0];
  logic signed [SW-1:0]  shift_q, shift_d;
  logic [M-1:0]          mant_q [N-1:0];
  logic [M-1:0]          mant_d [N-1:0];
  logic [E-1:0]          exp_q, exp_d;
  logic [BW-1:0]         lead [N-1:0];
  logic [BW-1:0]         b_max;
  logic signed [31:0]    e_full;

  // Bring one element to the shared scale; the scan guarantees the result fits M bits
  function automatic logic [M-1:0] scale(input logic [W-1:0] x, input logic signed [SW-1:0] sh);
    logic signed [W:0] xe;
    logic signed [W:0] r;
    logic [SW-1:0]     amt;
    xe = {x[W-1], x};
    if (sh > 0) begin
      amt = sh;
`ifdef MXINT_BLOCK_ENCODER_ROUND_EN
      xe = xe + ((W + 1)'(1) << (amt - SW'(1)));
      r  = xe >>> amt;
      if (r > MANT_MAX) r = MANT_MAX;
`else
      r  = xe >>> amt;
`endif
    end else begin
      amt = -sh;
      r   = xe << amt;
    end
    return r[M-1:0];
  endfunction

  for (genvar i = 0; i < N; i++) begin : g_lead
    mxint_leading_bit #(.W(W)) u_lead (
      .x (elem_q[i]),
      .b (lead[i])
    );
  end

  always_comb begin
    b_max = '0;
    for (int i = 0; i < N; i++) begin
      if (lead[i] > b_max) b_max = lead[i];
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    shift_d = shift_q;
    exp_d   = exp_q;
    e_full  = '0;
    for (int i = 0; i < N; i++) begin
      elem_d[i] = elem_q[i];
      mant_d[i] = mant_q[i];
    end
    case (state_q)
      COLLECT: begin
        if (data_in_0_valid) begin
          elem_d[count_q] = data_in_0;
          if (count_q == CW'(N - 1)) begin
            count_d = '0;
            state_d = SCAN;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      SCAN: begin
        shift_d = $signed(SW'(b_max)) - $signed(SW'(M - 1));
        state_d = SHIFT;
      end
      SHIFT: begin
        for (int i = 0; i < N; i++) mant_d[i] = scale(elem_q[i], shift_q);
        e_full = 32'(shift_q) - FRAC;
        if (e_full < E_MIN)      exp_d = E'(E_MIN);
        else if (e_full > E_MAX) exp_d = E'(E_MAX);
        else                     exp_d = e_full[E-1:0];
        state_d = OUT;
      end
      OUT: begin
        if (data_out_0_ready) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      count_q <= '0;
      shift_q <= '0;
      exp_q   <= '0;
      for (int i = 0; i < N; i++) begin
        elem_q[i] <= '0;
        mant_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shift_q <= shift_d;
      exp_q   <= exp_d;
      for (int i = 0; i < N; i++) begin
        elem_q[i] <= elem_d[i];
        mant_q[i] <= mant_d[i];
      end
    end
  end

  assign data_in_0_ready  = (state_q == COLLECT);
  assign data_out_0_valid = (state_q == OUT);
  assign edata_out_0      = exp_q;

  always_comb begin
    for (int i = 0; i < N; i++) mdata_out_0[i] = mant_q[i];
  end

endmodule

// File: tb/tb_mxint_block_encoder.sv
// tb/tb_mxint_block_encoder.sv - scoreboard bench for mxint_block_encoder
module tb_mxint_block_encoder;

  localparam int W    = 16;
  localparam int FRAC = 8;
  localparam int M    = 8;
  localparam int E    = 8;
  localparam int N    = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_in_0;
  logic         data_in_0_valid;
  logic         data_in_0_ready;
  logic [M-1:0] mdata_out_0 [N-1:0];
  logic [E-1:0] edata_out_0;
  logic         data_out_0_valid;
  logic         data_out_0_ready;

  always #5 clk = ~clk;

  mxint_block_encoder #(
    .DATA_IN_0_PRECISION_0  (W),
    .DATA_IN_0_PRECISION_1  (FRAC),
    .DATA_OUT_0_PRECISION_0 (M),
    .DATA_OUT_0_PRECISION_1 (E),
    .BLOCK_SIZE             (N)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .data_in_0        (data_in_0),
    .data_in_0_valid  (data_in_0_valid),
    .data_in_0_ready  (data_in_0_ready),
    .mdata_out_0      (mdata_out_0),
    .edata_out_0      (edata_out_0),
    .data_out_0_valid (data_out_0_valid),
    .data_out_0_ready (data_out_0_ready)
  );

  typedef struct packed {
    logic [N*M-1:0] m;
    logic [E-1:0]   e;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   rdy_mode = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic logic [N*M-1:0] dut_m();
    logic [N*M-1:0] r;
    for (int i = 0; i < N; i++) r[i*M +: M] = mdata_out_0[i];
    return r;
  endfunction

  function automatic exp_t mk(input int m0, input int m1, input int m2, input int m3, input int e);
    exp_t r;
    int   v[N];
    v = '{m0, m1, m2, m3};
    for (int i = 0; i < N; i++) r.m[i*M +: M] = v[i][M-1:0];
    r.e = e[E-1:0];
    return r;
  endfunction

  // Reference: B is the smallest n with -2^n <= x < 2^n, maximised over the block
  function automatic exp_t model(input int xs[N]);
    exp_t r;
    int   b_blk, n, sh, v, e;
    b_blk = 0;
    for (int i = 0; i < N; i++) begin
      n = 0;
      while (!(xs[i] >= -(1 << n) && xs[i] < (1 << n))) n++;
      if (n > b_blk) b_blk = n;
    end
    sh = b_blk - (M - 1);
    for (int i = 0; i < N; i++) begin
      if (sh > 0) begin
`ifdef MXINT_BLOCK_ENCODER_ROUND_EN
        v = (xs[i] + (1 << (sh - 1))) >>> sh;
        if (v > (1 << (M - 1)) - 1) v = (1 << (M - 1)) - 1;
`else
        v = xs[i] >>> sh;
`endif
      end else begin
        v = xs[i] * (1 << (-sh));
      end
      r.m[i*M +: M] = v[M-1:0];
    end
    e = sh - FRAC;
    if (e < -(1 << (E - 1)))    e = -(1 << (E - 1));
    if (e > (1 << (E - 1)) - 1) e = (1 << (E - 1)) - 1;
    r.e = e[E-1:0];
    return r;
  endfunction

  initial begin : monitor
    exp_t got, prev, want;
    bit   prev_stall, r;
    prev_stall = 1'b0;
    prev = '0;
    data_out_0_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        data_out_0_ready = 1'b0;
      end else begin
        case (rdy_mode)
          0:       r = 1'b1;
          1:       r = 1'($urandom_range(0, 1));
          default: r = 1'b0;
        endcase
        data_out_0_ready = r;
        got.m = dut_m();
        got.e = edata_out_0;
        if (data_out_0_valid && prev_stall) chk("hold_stable", got, prev);
        prev_stall = data_out_0_valid && !r;
        prev = got;
        if (data_out_0_valid && r) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_block: got m=%h e=%h with no block expected", got.m, got.e);
          end else begin
            want = exp_q.pop_front();
            chk("mantissas", got.m, want.m);
            chk("exponent", got.e, want.e);
          end
        end
      end
    end
  end

  task automatic send(input int v);
    int guard;
    bit acc;
    guard = 0;
    acc = 1'b0;
    while (!acc && guard < 300) begin
      @(negedge clk);
      data_in_0 = v[W-1:0];
      data_in_0_valid = 1'b1;
      acc = data_in_0_ready;
      guard++;
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: value %0d not accepted, ready=%b", v, data_in_0_ready);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      data_in_0_valid = 1'b0;
      data_in_0 = W'($urandom);
    end
  endtask

  task automatic send_block(input int xs[N], input exp_t want, input int max_gap);
    exp_q.push_back(want);
    for (int i = 0; i < N; i++) begin
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      send(xs[i]);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d blocks outstanding expected 0", exp_q.size());
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int   xs[N];
    int   g;
    exp_t s1;
    rst = 1'b1;
    data_in_0 = '0;
    data_in_0_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", data_out_0_valid, 0);
    chk("reset_in_ready", data_in_0_ready, 1);
    chk("reset_mdata", dut_m(), 0);
    chk("reset_edata", edata_out_0, 0);
    rst = 1'b0;

    // Scenario 1 with latency: valid exactly two edges after the last accept
    s1 = mk(64, -64, 32, 0, -6);
    xs = '{256, -256, 128, 0};
    send_block(xs, s1, 0);
    idle(1);
    chk("latency_scan", data_out_0_valid, 0);
    idle(1);
    chk("latency_shift", data_out_0_valid, 0);
    idle(1);
    chk("latency_out", data_out_0_valid, 1);
    idle(2);

    xs = '{0, 0, 0, 0};
    send_block(xs, mk(0, 0, 0, 0, -15), 0);
    xs = '{-32768, 1, 1, 1};
    send_block(xs, mk(-128, 0, 0, 0, 0), 0);
    xs = '{3, -2, 0, 1};
    send_block(xs, mk(96, -64, 0, 32, -13), 0);
    xs = '{259, 0, 0, 0};
`ifdef MXINT_BLOCK_ENCODER_ROUND_EN
    send_block(xs, mk(65, 0, 0, 0, -6), 0);
`else
    send_block(xs, mk(64, 0, 0, 0, -6), 0);
`endif
    xs = '{32767, 0, 0, 0};
    send_block(xs, mk(127, 0, 0, 0, 0), 0);
    idle(1);
    drain();

    // Backpressure: hold output, keep offering 77, which must start the next block
    rdy_mode = 2;
    xs = '{1000, -3, 5, 7};
    send_block(xs, model(xs), 0);
    fork
      begin
        repeat (8) begin
          @(negedge clk);
          chk("stall_in_ready", data_in_0_ready, 0);
        end
        chk("stall_out_valid", data_out_0_valid, 1);
        #2 rdy_mode = 0;
      end
      begin
        xs = '{77, -5, 300, 2};
        send_block(xs, model(xs), 0);
      end
    join
    idle(1);
    drain();

    // Reset after two beats: partial block discarded
    send(256);
    send(-256);
    @(negedge clk);
    data_in_0_valid = 1'b0;
    rst = 1'b1;
    #1 chk("rst_partial_valid", data_out_0_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    xs = '{256, -256, 128, 0};
    send_block(xs, s1, 0);
    idle(1);
    drain();

    // Reset while a block is pending at the output
    rdy_mode = 2;
    send(1);
    send(2);
    send(3);
    send(4);
    g = 0;
    while (!data_out_0_valid && g < 20) begin
      idle(1);
      g++;
    end
    chk("pending_valid", data_out_0_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", data_out_0_valid, 0);
    chk("rst_out_in_ready", data_in_0_ready, 1);
    chk("rst_out_mdata", dut_m(), 0);
    chk("rst_out_edata", edata_out_0, 0);
    @(negedge clk);
    rst = 1'b0;
    rdy_mode = 0;
    xs = '{256, -256, 128, 0};
    send_block(xs, s1, 0);
    idle(1);
    drain();

    // Random traffic with random backpressure
    rdy_mode = 1;
    for (int b = 0; b < 200; b++) begin
      for (int k = 0; k < N; k++) begin
        xs[k] = int'($signed(W'($urandom))) >>> $urandom_range(0, 15);
        if ($urandom_range(0, 19) == 0) xs[k] = -32768;
        else if ($urandom_range(0, 19) == 0) xs[k] = 32767;
      end
      send_block(xs, model(xs), 2);
    end
    idle(1);
    rdy_mode = 0;
    drain();
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
